// File: rtl/multi_tick_gen_pkg.sv
// Shared types for the multi-channel tick/duty generator.
// Mode encoding, default counter width and config bundle.
package tick_gen_pkg;

  localparam int CNT_W_DEF = 26;
  localparam int N_CH_MAX  = 16;

  typedef enum logic [1:0] {
    OFF     = 2'b00,
    CONT    = 2'b01,
    ONESHOT = 2'b10
  } mode_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] p;
    logic [CNT_W_DEF-1:0] h;
    mode_t                mode;
  } cfg_t;

  // Encoding 2'b11 is reserved and treated as off.
  function automatic mode_t to_mode(logic [1:0] m);
    mode_t r;
    r = OFF;
    unique case (m)
      2'b01:   r = CONT;
      2'b10:   r = ONESHOT;
      default: r = OFF;
    endcase
    return r;
  endfunction

  function automatic int ch_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_tick_gen_if.sv
// Configuration bus for multi_tick_gen.
// Master drives a single-cycle write strobe with channel and data.
interface multi_tick_gen_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 26
);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic [1:0]       cfg_mode;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_period,
    output cfg_high,
    output cfg_mode
  );

  modport slave (
    input cfg_we,
    input cfg_ch,
    input cfg_period,
    input cfg_high,
    input cfg_mode
  );

endinterface

// File: rtl/multi_tick_gen_channel.sv
// One tick/duty channel: counter, active and shadow config,
// registered tick/level/running outputs.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int               CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_P    = '0,
  parameter logic [CNT_W-1:0] RST_H    = '0,
  parameter mode_t            RST_MODE = OFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             we,
  input  logic [CNT_W-1:0] wr_p,
  input  logic [CNT_W-1:0] wr_h,
  input  mode_t            wr_mode,
  output logic             tick,
  output logic             level,
  output logic             running
);

  typedef struct packed {
    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] h;
    mode_t            mode;
  } ch_cfg_t;

  ch_cfg_t          act_q;
  ch_cfg_t          act_d;
  ch_cfg_t          sh_q;
  ch_cfg_t          sh_d;
  ch_cfg_t          wr_cfg;
  logic             pend_q;
  logic             pend_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             act_run;
  logic             at_end;
  logic             run_d;

  function automatic logic is_run(ch_cfg_t c);
    return (c.mode != OFF) && (c.p != '0);
  endfunction

  assign wr_cfg  = '{p: wr_p, h: wr_h, mode: wr_mode};
  assign act_run = is_run(act_q);
  assign at_end  = act_run &&
                   (cnt_q == act_q.p - CNT_W'(1));

  always_comb begin
    act_d  = act_q;
    sh_d   = sh_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (restart) begin
      if (we)
        act_d = wr_cfg;
      else if (pend_q)
        act_d = sh_q;
      pend_d = 1'b0;
      cnt_d  = '0;
    end else if (!act_run) begin
      if (we) begin
        act_d  = wr_cfg;
        pend_d = 1'b0;
      end
      cnt_d = '0;
    end else if (at_end) begin
      // Period boundary: the only point a new config may land.
      cnt_d  = '0;
      pend_d = 1'b0;
      if (we)
        act_d = wr_cfg;
      else if (pend_q)
        act_d = sh_q;
      else if (act_q.mode == ONESHOT)
        act_d.mode = OFF;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (we) begin
        sh_d   = wr_cfg;
        pend_d = 1'b1;
      end
    end
    run_d = is_run(act_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_q   <= '{p: RST_P, h: RST_H, mode: RST_MODE};
      sh_q    <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      tick    <= 1'b0;
      level   <= 1'b0;
      running <= 1'b0;
    end else begin
      act_q   <= act_d;
      sh_q    <= sh_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      tick    <= at_end && !restart;
      level   <= act_run && (cnt_q < act_q.h);
      running <= run_d;
    end
  end

endmodule

// File: rtl/multi_tick_gen.sv
// N_CH independent programmable tick/duty channels.
// Channel 0 comes out of reset as a free-running divider.
module multi_tick_gen
  import tick_gen_pkg::*;
#(
  parameter int          N_CH       = 4,
  parameter int          CNT_W      = CNT_W_DEF,
  parameter int unsigned CH0_PERIOD = 65_000_000,
  parameter int unsigned CH0_HIGH   = 32_500_000,
  localparam int         CH_W       = ch_w(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sync_restart,
  multi_tick_gen_if.slave cfg,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] running
);

  localparam logic [CNT_W-1:0] P0 = CNT_W'(CH0_PERIOD);
  localparam logic [CNT_W-1:0] H0 = CNT_W'(CH0_HIGH);
  localparam logic [CNT_W-1:0] Z  = '0;

  mode_t           wr_mode;
  logic [N_CH-1:0] ch_we;

  assign wr_mode = to_mode(cfg.cfg_mode);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Unmatched channel codes decode to no enable at all.
    assign ch_we[i] = cfg.cfg_we &&
                      (cfg.cfg_ch == CH_W'(i));

    tick_channel #(
      .CNT_W    (CNT_W),
      .RST_P    ((i == 0) ? P0 : Z),
      .RST_H    ((i == 0) ? H0 : Z),
      .RST_MODE ((i == 0) ? CONT : OFF)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (sync_restart),
      .we      (ch_we[i]),
      .wr_p    (cfg.cfg_period),
      .wr_h    (cfg.cfg_high),
      .wr_mode (wr_mode),
      .tick    (tick[i]),
      .level   (level[i]),
      .running (running[i])
    );
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed bench for multi_tick_gen (3 channels, ch0 P=10 H=5).
// Cycle k means the k-th cycle after the reference edge.
module tb_multi_tick_gen;
  import tick_gen_pkg::*;

  localparam int N_CH  = 3;
  localparam int CNT_W = 26;
  localparam int CH_W  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sync_restart = 1'b0;
  logic [N_CH-1:0] tick;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] running;

  int vecs = 0;
  int errs = 0;

  multi_tick_gen_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_bus ();

  multi_tick_gen #(
    .N_CH       (N_CH),
    .CNT_W      (CNT_W),
    .CH0_PERIOD (10),
    .CH0_HIGH   (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sync_restart (sync_restart),
    .cfg          (cfg_bus),
    .tick         (tick),
    .level        (level),
    .running      (running)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int p, input int h,
                    input logic [1:0] m);
    cfg_bus.cfg_we     = 1'b1;
    cfg_bus.cfg_ch     = CH_W'(ch);
    cfg_bus.cfg_period = CNT_W'(p);
    cfg_bus.cfg_high   = CNT_W'(h);
    cfg_bus.cfg_mode   = m;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_bus.cfg_we = 1'b0;
    sync_restart = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    vecs++;
    if (tick !== 3'b000) begin
      errs++;
      $display("FAIL rst_tick got %b want 000", tick);
    end
    vecs++;
    if (level !== 3'b000) begin
      errs++;
      $display("FAIL rst_level got %b want 000", level);
    end
    vecs++;
    if (running !== 3'b000) begin
      errs++;
      $display("FAIL rst_running got %b want 000", running);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ch0_period();
    logic [2:0] et, el;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      step();
      et = {2'b00, (k % 10) == 0};
      el = {2'b00, ((k - 1) % 10) < 5};
      vecs++;
      if (tick !== et) begin
        errs++;
        $display("FAIL ch0_tick c%0d got %b want %b", k, tick, et);
      end
      vecs++;
      if (level !== el) begin
        errs++;
        $display("FAIL ch0_level c%0d got %b want %b", k, level, el);
      end
      vecs++;
      if (running !== 3'b001) begin
        errs++;
        $display("FAIL ch0_run c%0d got %b want 001", k, running);
      end
    end
  endtask

  task automatic test_cont();
    logic et, el;
    do_reset();
    wr(1, 4, 2, 2'b01);
    for (int k = 1; k <= 13; k++) begin
      step();
      cfg_bus.cfg_we = 1'b0;
      et = (k == 5) || (k == 9) || (k == 13);
      el = (k >= 2) && (((k - 2) % 4) < 2);
      vecs++;
      if (tick[1] !== et) begin
        errs++;
        $display("FAIL cont_tick c%0d got %b want %b", k, tick[1], et);
      end
      vecs++;
      if (level[1] !== el) begin
        errs++;
        $display("FAIL cont_level c%0d got %b want %b", k, level[1], el);
      end
      vecs++;
      if (running[1] !== 1'b1) begin
        errs++;
        $display("FAIL cont_run c%0d got %b want 1", k, running[1]);
      end
    end
  endtask

  task automatic test_midwrite();
    logic [31:0] lm, tm;
    lm = (32'd1 << 2) | (32'd1 << 3) | (32'd1 << 6) | (32'd1 << 7) |
         (32'd1 << 8) | (32'd1 << 12) | (32'd1 << 13) | (32'd1 << 14);
    tm = (32'd1 << 5) | (32'd1 << 11) | (32'd1 << 17);
    do_reset();
    wr(1, 4, 2, 2'b01);
    for (int k = 1; k <= 17; k++) begin
      step();
      cfg_bus.cfg_we = 1'b0;
      if (k == 2)
        wr(1, 6, 3, 2'b01);
      vecs++;
      if (tick[1] !== tm[k]) begin
        errs++;
        $display("FAIL mid_tick c%0d got %b want %b", k, tick[1], tm[k]);
      end
      vecs++;
      if (level[1] !== lm[k]) begin
        errs++;
        $display("FAIL mid_level c%0d got %b want %b", k, level[1], lm[k]);
      end
    end
  endtask

  task automatic test_oneshot();
    logic er;
    do_reset();
    wr(2, 3, 1, 2'b10);
    for (int k = 1; k <= 12; k++) begin
      step();
      cfg_bus.cfg_we = 1'b0;
      er = (k >= 1) && (k <= 3);
      vecs++;
      if (running[2] !== er) begin
        errs++;
        $display("FAIL os_run c%0d got %b want %b", k, running[2], er);
      end
      vecs++;
      if (tick[2] !== (k == 4)) begin
        errs++;
        $display("FAIL os_tick c%0d got %b want %b", k, tick[2], k == 4);
      end
      vecs++;
      if (level[2] !== (k == 2)) begin
        errs++;
        $display("FAIL os_level c%0d got %b want %b", k, level[2], k == 2);
      end
    end
  endtask

  task automatic test_sync_restart();
    logic [1:0] et, el;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      step();
      cfg_bus.cfg_we = 1'b0;
      sync_restart = 1'b0;
      if (k == 3)
        wr(1, 10, 5, 2'b01);
      if (k == 9)
        sync_restart = 1'b1;
      et = ((k == 20) || (k == 30)) ? 2'b11 : 2'b00;
      vecs++;
      if (tick[1:0] !== et) begin
        errs++;
        $display("FAIL sync_tick c%0d got %b want %b", k, tick[1:0], et);
      end
      if (k >= 10) begin
        el = ((k >= 11) && (((k - 11) % 10) < 5)) ? 2'b11 : 2'b00;
        vecs++;
        if (level[1:0] !== el) begin
          errs++;
          $display("FAIL sync_level c%0d got %b want %b",
                   k, level[1:0], el);
        end
      end
    end
  endtask

  task automatic test_duty_edges();
    do_reset();
    wr(1, 4, 0, 2'b01);
    for (int k = 1; k <= 12; k++) begin
      step();
      cfg_bus.cfg_we = 1'b0;
      if (k == 1)
        wr(2, 3, 3, 2'b01);
      vecs++;
      if (level[1] !== 1'b0) begin
        errs++;
        $display("FAIL h0_level c%0d got %b want 0", k, level[1]);
      end
      vecs++;
      if (tick[1] !== ((k == 5) || (k == 9))) begin
        errs++;
        $display("FAIL h0_tick c%0d got %b want %b",
                 k, tick[1], (k == 5) || (k == 9));
      end
      vecs++;
      if (level[2] !== (k >= 3)) begin
        errs++;
        $display("FAIL hp_level c%0d got %b want %b", k, level[2], k >= 3);
      end
      vecs++;
      if (running[2] !== (k >= 2)) begin
        errs++;
        $display("FAIL hp_run c%0d got %b want %b", k, running[2], k >= 2);
      end
    end
  endtask

  task automatic test_p1_p0();
    do_reset();
    wr(1, 1, 1, 2'b01);
    for (int k = 1; k <= 10; k++) begin
      step();
      cfg_bus.cfg_we = 1'b0;
      if (k == 1)
        wr(2, 0, 0, 2'b01);
      if (k == 2)
        wr(3, 2, 1, 2'b01);
      vecs++;
      if (tick[1] !== (k >= 2)) begin
        errs++;
        $display("FAIL p1_tick c%0d got %b want %b", k, tick[1], k >= 2);
      end
      vecs++;
      if (running !== 3'b011) begin
        errs++;
        $display("FAIL p0_run c%0d got %b want 011", k, running);
      end
      vecs++;
      if (tick[2] !== 1'b0 || level[2] !== 1'b0) begin
        errs++;
        $display("FAIL p0_out c%0d got t%b l%b want t0 l0",
                 k, tick[2], level[2]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    wr(1, 4, 2, 2'b01);
    for (int k = 1; k <= 3; k++) begin
      step();
      cfg_bus.cfg_we = 1'b0;
    end
    vecs++;
    if (running !== 3'b011 || level[0] !== 1'b1) begin
      errs++;
      $display("FAIL pre_rst got r%b l%b want r011 l1", running, level[0]);
    end
    rst_n = 1'b0;
    step();
    vecs++;
    if ({tick, level, running} !== 9'd0) begin
      errs++;
      $display("FAIL mid_rst got t%b l%b r%b want all 0",
               tick, level, running);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      vecs++;
      if (tick !== ((k == 10) ? 3'b001 : 3'b000)) begin
        errs++;
        $display("FAIL post_rst_tick c%0d got %b", k, tick);
      end
    end
    vecs++;
    if (running !== 3'b001) begin
      errs++;
      $display("FAIL post_rst_run got %b want 001", running);
    end
  endtask

  initial begin
    cfg_bus.cfg_we     = 1'b0;
    cfg_bus.cfg_ch     = '0;
    cfg_bus.cfg_period = '0;
    cfg_bus.cfg_high   = '0;
    cfg_bus.cfg_mode   = 2'b00;
    test_reset();
    test_ch0_period();
    test_cont();
    test_midwrite();
    test_oneshot();
    test_sync_restart();
    test_duty_edges();
    test_p1_p0();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
